// File: rtl/rv_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rv_pkg : writeback selectors, load funct3 codes, commit-stage states       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package rv_pkg;

   typedef enum logic [1:0] {
      WB_ALU  = 2'd0,
      WB_LOAD = 2'd1,
      WB_PC4  = 2'd2,
      WB_NONE = 2'd3
   } wb_sel_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic {
      IDLE     = 1'b0,
      WAIT_MEM = 1'b1
   } wb_state_e;

endpackage
`default_nettype wire

// File: rtl/load_formatter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | load_formatter : extracts and extends a byte/halfword/word from a load    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module load_formatter
   import rv_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  off,
   input  logic [31:0] rdata,
   output logic [31:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[{off, 3'b000} +: 8];
      half_sel = off[1] ? rdata[31:16] : rdata[15:0];
      case (funct3)
         F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
         F3_LBU:  result = {24'd0, byte_sel};
         F3_LH:   result = {{16{half_sel[15]}}, half_sel};
         F3_LHU:  result = {16'd0, half_sel};
         default: result = rdata;  // LW and any undefined encoding
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/wb_commit_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_commit_unit : writeback/commit stage driving the register-file port,   |
// | with load wait/timeout, forwarding of the in-flight write and load stall  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module wb_commit_unit
   import rv_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_valid,
   output logic        ex_ready,
   input  logic [4:0]  ex_rd,
   input  logic [1:0]  ex_wb_sel,
   input  logic [2:0]  ex_funct3,
   input  logic [31:0] ex_alu_result,
   input  logic [31:0] ex_pc4,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata,
   output logic        rf_wr,
   output logic [4:0]  rf_rd,
   output logic [31:0] rf_wdata,
   input  logic [4:0]  dec_rs1,
   input  logic [4:0]  dec_rs2,
   output logic        fwd_hit1,
   output logic        fwd_hit2,
   output logic [31:0] fwd_data1,
   output logic [31:0] fwd_data2,
   output logic        ld_stall,
   output logic        load_err
);

   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

   wb_state_e         state;
   logic [CNT_W-1:0]  cnt;
   logic [4:0]        pend_rd;
   logic [2:0]        pend_funct3;
   logic [1:0]        pend_off;
   logic [31:0]       fmt_data;
   logic              accept;

   load_formatter u_load_formatter (
      .funct3 (pend_funct3),
      .off    (pend_off),
      .rdata  (dmem_rdata),
      .result (fmt_data)
   );

   assign ex_ready = (state == IDLE);
   assign accept   = ex_valid & ex_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         rf_wr       <= 1'b0;
         rf_rd       <= '0;
         rf_wdata    <= '0;
         load_err    <= 1'b0;
         cnt         <= '0;
         pend_rd     <= '0;
         pend_funct3 <= '0;
         pend_off    <= '0;
      end else begin
         rf_wr    <= 1'b0;
         load_err <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  case (ex_wb_sel)
                     WB_ALU, WB_PC4: begin
                        // rd/wdata only move on a real write so they hold otherwise
                        if (ex_rd != 5'd0) begin
                           rf_wr    <= 1'b1;
                           rf_rd    <= ex_rd;
                           rf_wdata <= (ex_wb_sel == WB_PC4) ? ex_pc4 : ex_alu_result;
                        end
                     end
                     WB_LOAD: begin
                        pend_rd     <= ex_rd;
                        pend_funct3 <= ex_funct3;
                        pend_off    <= ex_alu_result[1:0];
                        cnt         <= '0;
                        state       <= WAIT_MEM;
                     end
                     default: ;
                  endcase
               end
            end
            WAIT_MEM: begin
               // A response on the final allowed cycle still beats the timeout
               if (dmem_rvalid) begin
                  if (pend_rd != 5'd0) begin
                     rf_wr    <= 1'b1;
                     rf_rd    <= pend_rd;
                     rf_wdata <= fmt_data;
                  end
                  state <= IDLE;
               end else if (cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
                  load_err <= 1'b1;
                  state    <= IDLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign fwd_hit1  = rf_wr & (rf_rd == dec_rs1) & (dec_rs1 != 5'd0);
   assign fwd_hit2  = rf_wr & (rf_rd == dec_rs2) & (dec_rs2 != 5'd0);
   assign fwd_data1 = fwd_hit1 ? rf_wdata : '0;
   assign fwd_data2 = fwd_hit2 ? rf_wdata : '0;

   assign ld_stall = (state == WAIT_MEM) & (pend_rd != 5'd0) &
                     ((pend_rd == dec_rs1) | (pend_rd == dec_rs2));

endmodule
`default_nettype wire

// File: tb/tb_wb_commit_unit.sv
`default_nettype none
// Bench for wb_commit_unit: vector table, hand sequences for reset/timeout, and
// randomized transactions checked against a transaction-level model.
module tb_wb_commit_unit;
   import rv_pkg::*;

   localparam int MEM_TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid, ex_ready;
   logic [4:0]  ex_rd;
   logic [1:0]  ex_wb_sel;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_alu_result, ex_pc4;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic        rf_wr;
   logic [4:0]  rf_rd;
   logic [31:0] rf_wdata;
   logic [4:0]  dec_rs1, dec_rs2;
   logic        fwd_hit1, fwd_hit2;
   logic [31:0] fwd_data1, fwd_data2;
   logic        ld_stall, load_err;

   wb_commit_unit #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_wb_sel(ex_wb_sel),
      .ex_funct3(ex_funct3), .ex_alu_result(ex_alu_result), .ex_pc4(ex_pc4),
      .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
      .rf_wr(rf_wr), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
      .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
      .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
      .ld_stall(ld_stall), .load_err(load_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  sel;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic [31:0] alu;
      logic [31:0] pc4;
      int          delay;    // idle WAIT_MEM cycles before the response
      bit          respond;
      logic [31:0] rdata;
      bit          exp_wr;
      logic [31:0] exp_wdata;
   } vec_t;

   int n_tests = 0;
   int n_fail  = 0;
   logic [4:0]  last_rd    = 5'd0;
   logic [31:0] last_wdata = 32'd0;
   vec_t tbl[16];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Load result from the ISA definition, using shifts and integer arithmetic
   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] w);
      logic [31:0] b, h;
      b = (w >> (8 * int'(off))) & 32'hFF;
      h = (w >> (16 * (int'(off) / 2))) & 32'hFFFF;
      case (f3)
         3'b000:  return (b >= 32'd128)   ? b - 32'd256   : b;
         3'b100:  return b;
         3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
         3'b101:  return h;
         default: return w;
      endcase
   endfunction

   task automatic check_write(input string tag, input vec_t v, input logic [4:0] rs2);
      chk({tag, " rf_wr"}, 32'(rf_wr), 32'(v.exp_wr));
      if (v.exp_wr) begin
         last_rd    = v.rd;
         last_wdata = v.exp_wdata;
      end
      chk({tag, " rf_rd"}, 32'(rf_rd), 32'(last_rd));
      chk({tag, " rf_wdata"}, rf_wdata, last_wdata);
      dec_rs1 = v.rd;
      dec_rs2 = rs2;
      #1;
      chk({tag, " fwd_hit1"}, 32'(fwd_hit1), 32'(v.exp_wr));
      chk({tag, " fwd_data1"}, fwd_data1, v.exp_wr ? v.exp_wdata : 32'd0);
      chk({tag, " fwd_hit2"}, 32'(fwd_hit2), 32'(v.exp_wr && rs2 == v.rd));
      chk({tag, " fwd_data2"}, fwd_data2, (v.exp_wr && rs2 == v.rd) ? v.exp_wdata : 32'd0);
   endtask

   // Starts in IDLE between edges; for non-loads returns without an extra edge so
   // successive calls give back-to-back accepts.
   task automatic run_op(input string tag, input vec_t v, input logic [4:0] rs2);
      bit done;
      ex_valid = 1'b1; ex_rd = v.rd; ex_wb_sel = v.sel; ex_funct3 = v.f3;
      ex_alu_result = v.alu; ex_pc4 = v.pc4;
      dec_rs1 = 5'd0; dec_rs2 = v.rd;
      #1;
      chk({tag, " ex_ready pre"}, 32'(ex_ready), 32'd1);
      tick();
      ex_valid = 1'b0;
      if (v.sel != WB_LOAD) begin
         chk({tag, " ex_ready post"}, 32'(ex_ready), 32'd1);
         check_write(tag, v, rs2);
         return;
      end
      chk({tag, " accept rf_wr"}, 32'(rf_wr), 32'd0);
      done = 1'b0;
      for (int k = 1; k <= MEM_TIMEOUT && !done; k++) begin
         chk({tag, " wait ex_ready"}, 32'(ex_ready), 32'd0);
         chk({tag, " wait ld_stall"}, 32'(ld_stall), 32'(v.rd != 5'd0));
         if (v.respond && k == v.delay + 1) begin
            dmem_rvalid = 1'b1;
            dmem_rdata  = v.rdata;
            tick();
            dmem_rvalid = 1'b0;
            dmem_rdata  = $urandom;
            chk({tag, " resp load_err"}, 32'(load_err), 32'd0);
            chk({tag, " resp ex_ready"}, 32'(ex_ready), 32'd1);
            chk({tag, " resp ld_stall"}, 32'(ld_stall), 32'd0);
            check_write(tag, v, rs2);
            done = 1'b1;
         end else begin
            tick();
            if (k == MEM_TIMEOUT) begin
               chk({tag, " timeout load_err"}, 32'(load_err), 32'd1);
               chk({tag, " timeout rf_wr"}, 32'(rf_wr), 32'd0);
               chk({tag, " timeout ex_ready"}, 32'(ex_ready), 32'd1);
               tick();
               chk({tag, " load_err pulse"}, 32'(load_err), 32'd0);
               done = 1'b1;
            end else begin
               chk({tag, " early load_err"}, 32'(load_err), 32'd0);
               chk({tag, " early rf_wr"}, 32'(rf_wr), 32'd0);
            end
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      vec_t v;
      rst_n = 1'b0; ex_valid = 1'b0; ex_rd = '0; ex_wb_sel = '0; ex_funct3 = '0;
      ex_alu_result = '0; ex_pc4 = '0; dmem_rvalid = 1'b0; dmem_rdata = '0;
      dec_rs1 = '0; dec_rs2 = '0;

      tbl[0]  = '{WB_ALU,  5'd1,  3'b000, 32'h11,        32'h0,    0, 1'b0, 32'h0,        1'b1, 32'h11};
      tbl[1]  = '{WB_ALU,  5'd2,  3'b000, 32'h22,        32'h0,    0, 1'b0, 32'h0,        1'b1, 32'h22};
      tbl[2]  = '{WB_ALU,  5'd3,  3'b000, 32'h33,        32'h0,    0, 1'b0, 32'h0,        1'b1, 32'h33};
      tbl[3]  = '{WB_PC4,  5'd9,  3'b000, 32'hAAAA,      32'h1004, 0, 1'b0, 32'h0,        1'b1, 32'h1004};
      tbl[4]  = '{WB_NONE, 5'd6,  3'b000, 32'h66,        32'h0,    0, 1'b0, 32'h0,        1'b0, 32'h0};
      tbl[5]  = '{WB_ALU,  5'd4,  3'b000, 32'hDEADBEEF,  32'h0,    0, 1'b0, 32'h0,        1'b1, 32'hDEADBEEF};
      tbl[6]  = '{WB_ALU,  5'd0,  3'b000, 32'h55,        32'h0,    0, 1'b0, 32'h0,        1'b0, 32'h0};
      tbl[7]  = '{WB_LOAD, 5'd5,  3'b000, 32'h102,       32'h0,    2, 1'b1, 32'h12803456, 1'b1, 32'hFFFFFF80};
      tbl[8]  = '{WB_LOAD, 5'd5,  3'b100, 32'h102,       32'h0,    2, 1'b1, 32'h12803456, 1'b1, 32'h00000080};
      tbl[9]  = '{WB_LOAD, 5'd8,  3'b101, 32'h206,       32'h0,    1, 1'b1, 32'hBEEF1234, 1'b1, 32'h0000BEEF};
      tbl[10] = '{WB_LOAD, 5'd8,  3'b001, 32'h200,       32'h0,    0, 1'b1, 32'h12348001, 1'b1, 32'hFFFF8001};
      tbl[11] = '{WB_LOAD, 5'd10, 3'b010, 32'h303,       32'h0,    4, 1'b1, 32'hCAFEBABE, 1'b1, 32'hCAFEBABE};
      tbl[12] = '{WB_LOAD, 5'd10, 3'b011, 32'h301,       32'h0,    0, 1'b1, 32'h80000001, 1'b1, 32'h80000001};
      tbl[13] = '{WB_LOAD, 5'd0,  3'b000, 32'h0,         32'h0,    0, 1'b1, 32'hFFFFFFFF, 1'b0, 32'h0};
      tbl[14] = '{WB_LOAD, 5'd7,  3'b010, 32'h0,         32'h0,    0, 1'b0, 32'h0,        1'b0, 32'h0};
      tbl[15] = '{WB_LOAD, 5'd11, 3'b000, 32'h3,         32'h0,    MEM_TIMEOUT - 1, 1'b1, 32'h9A00007F, 1'b1, 32'hFFFFFF9A};

      // Reset state
      #12;
      chk("reset rf_wr", 32'(rf_wr), 32'd0);
      chk("reset rf_rd", 32'(rf_rd), 32'd0);
      chk("reset rf_wdata", rf_wdata, 32'd0);
      chk("reset load_err", 32'(load_err), 32'd0);
      chk("reset ex_ready", 32'(ex_ready), 32'd1);
      chk("reset ld_stall", 32'(ld_stall), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // Vector table; the first three rows form a back-to-back ALU stream
      for (int i = 0; i < 16; i++) run_op($sformatf("vec%0d", i), tbl[i], tbl[i].rd);
      tick();
      chk("idle rf_wr", 32'(rf_wr), 32'd0);
      chk("idle rf_rd hold", 32'(rf_rd), 32'(last_rd));

      // dmem_rvalid in IDLE must not produce a write
      dmem_rvalid = 1'b1; dmem_rdata = 32'h12345678;
      tick();
      dmem_rvalid = 1'b0;
      chk("idle rvalid rf_wr", 32'(rf_wr), 32'd0);
      chk("idle rvalid ex_ready", 32'(ex_ready), 32'd1);

      // Reset mid-load after a visible write
      v = '{WB_ALU, 5'd12, 3'b000, 32'h1234, 32'h0, 0, 1'b0, 32'h0, 1'b1, 32'h1234};
      run_op("pre_rst", v, 5'd12);
      ex_valid = 1'b1; ex_wb_sel = WB_LOAD; ex_rd = 5'd7; ex_funct3 = F3_LW; ex_alu_result = 32'h40;
      dec_rs1 = 5'd7; dec_rs2 = 5'd0;
      tick();
      ex_valid = 1'b0;
      tick();
      chk("mid-load ld_stall", 32'(ld_stall), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async rst rf_rd", 32'(rf_rd), 32'd0);
      chk("async rst rf_wdata", rf_wdata, 32'd0);
      chk("async rst rf_wr", 32'(rf_wr), 32'd0);
      chk("async rst ex_ready", 32'(ex_ready), 32'd1);
      chk("async rst ld_stall", 32'(ld_stall), 32'd0);
      last_rd = 5'd0; last_wdata = 32'd0;
      tick();
      rst_n = 1'b1;
      tick();
      dmem_rvalid = 1'b1; dmem_rdata = 32'hA5A5A5A5;
      tick();
      dmem_rvalid = 1'b0;
      chk("post rst rvalid rf_wr", 32'(rf_wr), 32'd0);
      chk("post rst rvalid load_err", 32'(load_err), 32'd0);
      chk("post rst rf_wdata", rf_wdata, 32'd0);

      // Randomized transactions against the reference model
      for (int i = 0; i < 200; i++) begin
         logic [4:0] rs2;
         v.sel     = 2'($urandom_range(0, 3));
         v.rd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         v.f3      = 3'($urandom_range(0, 7));
         v.alu     = $urandom;
         v.pc4     = $urandom;
         v.rdata   = $urandom;
         v.delay   = $urandom_range(0, MEM_TIMEOUT - 1);
         v.respond = ($urandom_range(0, 4) != 0);
         case (v.sel)
            WB_ALU:  v.exp_wdata = v.alu;
            WB_PC4:  v.exp_wdata = v.pc4;
            WB_LOAD: v.exp_wdata = ref_load(v.f3, v.alu[1:0], v.rdata);
            default: v.exp_wdata = 32'd0;
         endcase
         v.exp_wr = (v.rd != 5'd0) && (v.sel == WB_ALU || v.sel == WB_PC4 ||
                                       (v.sel == WB_LOAD && v.respond));
         rs2 = $urandom_range(0, 1) ? v.rd : 5'($urandom_range(0, 31));
         run_op($sformatf("rnd%0d", i), v, rs2);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/wb_commit_unit.md
Name: wb_commit_unit

Overview:
- Writeback/commit stage of the 3-stage RISC-V pipeline: the initiator that drives the register file write port (rf_wr, rd, wdata).
- Accepts completed instructions from execute over a valid/ready handshake and selects the result (ALU, load, PC+4).
- Waits for data-memory responses on loads and formats sub-word loads; issues one registered write per instruction.
- Provides decode with forwarding of the in-flight write and a load-use stall.

Parameters:
- MEM_TIMEOUT, 16, max cycles in WAIT_MEM before load abort (>=2).
- CNT_W, $clog2(MEM_TIMEOUT+1), timeout counter width (derived, not overridden).

Ports:
- clk  in  1  clock, all state on posedge
- rst_n  in  1  reset, asynchronous, active-low
- ex_valid  in  1  execute result valid
- ex_ready  out  1  unit can accept result
- ex_rd  in  5  destination register
- ex_wb_sel  in  2  result source: WB_ALU/WB_LOAD/WB_PC4/WB_NONE
- ex_funct3  in  3  load type (LB 000, LH 001, LW 010, LBU 100, LHU 101)
- ex_alu_result  in  32  ALU result / load address
- ex_pc4  in  32  PC+4 for jal/jalr
- dmem_rvalid  in  1  load response valid (single-cycle pulse)
- dmem_rdata  in  32  load response word
- rf_wr  out  1  register file write enable
- rf_rd  out  5  write address
- rf_wdata  out  32  write data
- dec_rs1, dec_rs2  in  5 each  decode source registers
- fwd_hit1, fwd_hit2  out  1 each  forwarding valid for rs1/rs2
- fwd_data1, fwd_data2  out  32 each  forwarded value
- ld_stall  out  1  decode must stall (load-use)
- load_err  out  1  one-cycle pulse on load timeout

Behaviour:
- Reset (rst_n low, any state): state=IDLE; rf_wr=0, rf_rd=0, rf_wdata=0, load_err=0, counter=0, pending rd/funct3/offset=0. Reset is honoured mid-load; the pending load is dropped.
- States: IDLE, WAIT_MEM.
- IDLE: ex_ready=1. Accept = ex_valid & ex_ready.
  - Accept with WB_ALU or WB_PC4: next cycle rf_wr=(ex_rd!=0), rf_rd=ex_rd, rf_wdata=selected value. Latency is 1 cycle; back-to-back accepts give 1 write/cycle.
  - Accept with WB_NONE: rf_wr=0 next cycle.
  - Accept with WB_LOAD: capture rd, funct3, ex_alu_result[1:0]; counter=0; rf_wr=0 next cycle; go to WAIT_MEM.
  - No accept: rf_wr=0.
- WAIT_MEM: ex_ready=0; execute holds inputs stable. Counter increments each cycle without a response.
  - dmem_rvalid: next cycle rf_wr=(pend_rd!=0), rf_wdata=formatted data; return to IDLE.
  - No response when counter==MEM_TIMEOUT-1: next cycle load_err=1 for one cycle, no write, return to IDLE.
  - Response and timeout in the same cycle: the response wins, no load_err.
- dmem_rvalid in IDLE is ignored.
- Load formatting by offset off:
  - LB/LBU: byte off, sign-/zero-extended.
  - LH/LHU: halfword off[1], sign-/zero-extended.
  - LW: full word, off ignored.
  - Undefined funct3: treated as LW.
- rf_rd and rf_wdata hold their last value when rf_wr=0.
- Forwarding (combinational from registered outputs): fwd_hitN = rf_wr & (rf_rd==dec_rsN) & (dec_rsN!=0); fwd_dataN = rf_wdata when hit, else 0. This covers the register file write landing on the same edge as the decode read.
- ld_stall = (state==WAIT_MEM) & (pend_rd!=0) & (pend_rd==dec_rs1 | pend_rd==dec_rs2).
- x0 is never written: rf_wr stays 0 for rd=0 in every path.

Decomposition:
- Shared package rv_pkg:
  - wb_sel_e enum (WB_ALU=0, WB_LOAD=1, WB_PC4=2, WB_NONE=3).
  - funct3 load constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
  - wb_state_e (IDLE, WAIT_MEM).
- Sub-module load_formatter: combinational, inputs funct3, off, rdata; output 32-bit result. Reusable by any future LSU.

Test Plan:
- ALU stream: three accepts on consecutive cycles, rd=1,2,3, alu=0x11/0x22/0x33 -> rf_wr high for 3 consecutive cycles starting 1 cycle after the first accept, with matching rd/wdata; ex_ready stays 1.
- LB sign-extension: load rd=5, funct3=000, addr=...02, rdata=0x12_80_34_56 after 3 cycles -> ex_ready=0 for 3 cycles, then one write rd=5, wdata=0xFFFFFF80; with LBU -> 0x00000080. LHU with addr off=2 and rdata=0xBEEF1234 -> 0x0000BEEF.
- Load-use stall: pending load rd=7, dec_rs2=7 -> ld_stall=1 until the response cycle, 0 after; dec_rs1=0 with rd=0 -> never stalls.
- Forwarding: write rd=4, wdata=0xDEADBEEF with dec_rs1=4, dec_rs2=4 in the same cycle -> fwd_hit1=fwd_hit2=1, fwd_data=0xDEADBEEF; rd=0 -> no hit, no rf_wr.
- Timeout: load with no dmem_rvalid -> load_err pulses exactly at cycle MEM_TIMEOUT, no write, ex_ready=1 next cycle. Response arriving on the timeout cycle -> write occurs, load_err=0.
- Reset in WAIT_MEM: assert rst_n low mid-load -> all outputs 0 immediately; a later dmem_rvalid is ignored, with no write.
